// File: rtl/shift_reg_pkg.sv
// Shared mode encodings and helpers for the universal shift register.
package shift_reg_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD     = 3'b000,
    MODE_SHR      = 3'b001,
    MODE_SHL      = 3'b010,
    MODE_ROR      = 3'b011,
    MODE_ROL      = 3'b100,
    MODE_LOAD     = 3'b101,
    MODE_CLEAR    = 3'b110,
    MODE_RESERVED = 3'b111
  } mode_e;

  function automatic logic is_shift(input mode_e m);
    return (m == MODE_SHR) || (m == MODE_SHL) || (m == MODE_ROR) || (m == MODE_ROL);
  endfunction

  function automatic logic is_restart(input mode_e m);
    return (m == MODE_LOAD) || (m == MODE_CLEAR);
  endfunction

endpackage

// File: rtl/shift_bit_counter.sv
// Counts shift/rotate operations modulo WIDTH and emits a registered
// one-cycle Frame_Done pulse on the edge where the count wraps.
module shift_bit_counter #(
  parameter int WIDTH = 4,
  parameter int CW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          step,
  input  logic          restart,
  output logic [CW-1:0] Bit_Count,
  output logic          Frame_Done
);

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;

  // Restart wins over step; any idle edge clears the pulse.
  always_comb begin
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (restart) begin
      cnt_d = '0;
    end else if (step) begin
      if (cnt_q == LAST) begin
        cnt_d  = '0;
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign Bit_Count  = cnt_q;
  assign Frame_Done = done_q;

endmodule

// File: rtl/shift_register_universal.sv
// Universal shift register: hold, shift/rotate both ways, parallel load and
// clear, with a frame counter tracking shift operations.
module shift_register_universal
  import shift_reg_pkg::*;
#(
  parameter int               WIDTH       = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     Enable,
  input  logic [2:0]               Mode,
  input  logic                     Serial_IN,
  input  logic [WIDTH-1:0]         Parallel_IN,
  output logic                     Serial_OUT_R,
  output logic                     Serial_OUT_L,
  output logic [WIDTH-1:0]         q,
  output logic [$clog2(WIDTH)-1:0] Bit_Count,
  output logic                     Frame_Done
);

  mode_e            mode;
  logic [WIDTH-1:0] q_q, q_d;

  assign mode = mode_e'(Mode);

  always_comb begin
    q_d = q_q;
    if (Enable) begin
      unique case (mode)
        MODE_SHR:   q_d = {Serial_IN, q_q[WIDTH-1:1]};
        MODE_SHL:   q_d = {q_q[WIDTH-2:0], Serial_IN};
        MODE_ROR:   q_d = {q_q[0], q_q[WIDTH-1:1]};
        MODE_ROL:   q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
        MODE_LOAD:  q_d = Parallel_IN;
        MODE_CLEAR: q_d = '0;
        default:    q_d = q_q;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) q_q <= RESET_VALUE;
    else     q_q <= q_d;
  end

  shift_bit_counter #(
    .WIDTH (WIDTH),
    .CW    ($clog2(WIDTH))
  ) u_counter (
    .CLK        (CLK),
    .RST        (RST),
    .step       (Enable && is_shift(mode)),
    .restart    (Enable && is_restart(mode)),
    .Bit_Count  (Bit_Count),
    .Frame_Done (Frame_Done)
  );

  assign q            = q_q;
  assign Serial_OUT_R = q_q[0];
  assign Serial_OUT_L = q_q[WIDTH-1];

endmodule

// File: tb/tb_shift_register_universal.sv
// Directed bench for shift_register_universal at WIDTH=4, RESET_VALUE=0.
module tb_shift_register_universal;

  logic       CLK = 1'b0;
  logic       RST;
  logic       Enable;
  logic [2:0] Mode;
  logic       Serial_IN;
  logic [3:0] Parallel_IN;
  logic       Serial_OUT_R, Serial_OUT_L;
  logic [3:0] q;
  logic [1:0] Bit_Count;
  logic       Frame_Done;

  int checks = 0;
  int errors = 0;

  shift_register_universal #(.WIDTH(4), .RESET_VALUE(4'b0000)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .Enable       (Enable),
    .Mode         (Mode),
    .Serial_IN    (Serial_IN),
    .Parallel_IN  (Parallel_IN),
    .Serial_OUT_R (Serial_OUT_R),
    .Serial_OUT_L (Serial_OUT_L),
    .q            (q),
    .Bit_Count    (Bit_Count),
    .Frame_Done   (Frame_Done)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [3:0] eq, input logic [1:0] ebc,
                           input logic efd);
    chk({tag, ".q"}, 32'(q), 32'(eq));
    chk({tag, ".bc"}, 32'(Bit_Count), 32'(ebc));
    chk({tag, ".fd"}, 32'(Frame_Done), 32'(efd));
    $display("step %s: q=%b bc=%0d fd=%b", tag, q, Bit_Count, Frame_Done);
  endtask

  task automatic edge_op(input logic en, input logic [2:0] m, input logic sin,
                         input logic [3:0] pin);
    Enable = en; Mode = m; Serial_IN = sin; Parallel_IN = pin;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b1; Enable = 1'b0; Mode = 3'b000; Serial_IN = 1'b0; Parallel_IN = 4'b0000;
    #1;
    chk_state("reset0", 4'b0000, 2'd0, 1'b0);
    @(negedge CLK); RST = 1'b0;

    // Async reset with q=1011 between edges
    edge_op(1, 3'b101, 0, 4'b1011); chk_state("load1011", 4'b1011, 2'd0, 1'b0);
    edge_op(1, 3'b001, 0, 4'b0000); chk_state("shr_pre", 4'b0101, 2'd1, 1'b0);
    edge_op(1, 3'b101, 0, 4'b1011); chk_state("reload", 4'b1011, 2'd0, 1'b0);
    #2 RST = 1'b1; #1;
    chk_state("async_rst", 4'b0000, 2'd0, 1'b0);
    @(negedge CLK); RST = 1'b0;

    // Shift right 1,0,1,1
    edge_op(1, 3'b001, 1, 4'b1111); chk_state("shr1", 4'b1000, 2'd1, 1'b0);
    chk("shr1.sor", 32'(Serial_OUT_R), 32'd0); chk("shr1.sol", 32'(Serial_OUT_L), 32'd1);
    edge_op(1, 3'b001, 0, 4'b1111); chk_state("shr2", 4'b0100, 2'd2, 1'b0);
    chk("shr2.sor", 32'(Serial_OUT_R), 32'd0); chk("shr2.sol", 32'(Serial_OUT_L), 32'd0);
    edge_op(1, 3'b001, 1, 4'b1111); chk_state("shr3", 4'b1010, 2'd3, 1'b0);
    chk("shr3.sor", 32'(Serial_OUT_R), 32'd0); chk("shr3.sol", 32'(Serial_OUT_L), 32'd1);
    edge_op(1, 3'b001, 1, 4'b1111); chk_state("shr4", 4'b1101, 2'd0, 1'b1);
    chk("shr4.sor", 32'(Serial_OUT_R), 32'd1); chk("shr4.sol", 32'(Serial_OUT_L), 32'd1);
    edge_op(1, 3'b000, 1, 4'b1111); chk_state("hold_after", 4'b1101, 2'd0, 1'b0);

    // Load 1001 then rotate left x4 (Serial_IN must be ignored)
    edge_op(1, 3'b101, 0, 4'b1001); chk_state("load1001", 4'b1001, 2'd0, 1'b0);
    edge_op(1, 3'b100, 0, 4'b0000); chk_state("rol1", 4'b0011, 2'd1, 1'b0);
    edge_op(1, 3'b100, 0, 4'b0000); chk_state("rol2", 4'b0110, 2'd2, 1'b0);
    edge_op(1, 3'b100, 0, 4'b0000); chk_state("rol3", 4'b1100, 2'd3, 1'b0);
    edge_op(1, 3'b100, 0, 4'b0000); chk_state("rol4", 4'b1001, 2'd0, 1'b1);

    // Mixed directions count together
    edge_op(1, 3'b011, 0, 4'b0000); chk_state("ror1", 4'b1100, 2'd1, 1'b0);
    edge_op(1, 3'b010, 0, 4'b1111); chk_state("shl1", 4'b1000, 2'd2, 1'b0);

    // Enable gating and reserved mode
    for (int i = 0; i < 3; i++) begin
      edge_op(0, 3'b001, 1, 4'b1111); chk_state("en0", 4'b1000, 2'd2, 1'b0);
    end
    for (int i = 0; i < 3; i++) begin
      edge_op(1, 3'b111, 1, 4'b1111); chk_state("rsvd", 4'b1000, 2'd2, 1'b0);
    end
    edge_op(1, 3'b010, 1, 4'b0000); chk_state("shl2", 4'b0001, 2'd3, 1'b0);
    edge_op(1, 3'b010, 1, 4'b0000); chk_state("shl3", 4'b0011, 2'd0, 1'b1);

    // Mid-frame reset, then a full frame is required
    edge_op(1, 3'b001, 0, 4'b0000); chk_state("mf1", 4'b0001, 2'd1, 1'b0);
    edge_op(1, 3'b001, 0, 4'b0000); chk_state("mf2", 4'b0000, 2'd2, 1'b0);
    #2 RST = 1'b1; #1;
    chk_state("mf_rst", 4'b0000, 2'd0, 1'b0);
    @(negedge CLK); RST = 1'b0;
    edge_op(1, 3'b001, 1, 4'b0000); chk_state("mf3", 4'b1000, 2'd1, 1'b0);
    edge_op(1, 3'b001, 1, 4'b0000); chk_state("mf4", 4'b1100, 2'd2, 1'b0);
    edge_op(1, 3'b001, 1, 4'b0000); chk_state("mf5", 4'b1110, 2'd3, 1'b0);
    edge_op(1, 3'b001, 1, 4'b0000); chk_state("mf6", 4'b1111, 2'd0, 1'b1);
    edge_op(1, 3'b001, 1, 4'b0000); chk_state("mf7", 4'b1111, 2'd1, 1'b0);
    edge_op(1, 3'b110, 1, 4'b1010); chk_state("clear", 4'b0000, 2'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
